// File: rtl/dtc_pkg.sv
// Shared types and helpers for the decision-tree classifier stream driver.
// Default widths, the result record and the saturating counter step.
package dtc_pkg;

    localparam int DTC_FEAT_W = 8;
    localparam int DTC_CLS_W  = 2;

    typedef struct packed {
        logic [DTC_FEAT_W-1:0] feat;
        logic [DTC_CLS_W-1:0]  cls;
    } dtc_res_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] lim;
        lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/dtc_result_fifo.sv
// Generic synchronous FIFO with registered storage and mux-read head.
// Push while full and pop while empty are ignored; no fall-through.
module dtc_result_fifo
    import dtc_pkg::*;
#(
    parameter int W     = DTC_FEAT_W + DTC_CLS_W,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (lvl_q == LW'(DEPTH));
    assign empty   = (lvl_q == '0);
    assign level   = lvl_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next state; pointers wrap at DEPTH.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    // Storage and pointer registers; reset clears entries so the head is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
            if (do_push) mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/dtc_stream_driver.sv
// Stream front/back end for a combinational decision-tree classifier.
// Stage register drives the tree; results queue in a FIFO; per-class hits.
module dtc_stream_driver
    import dtc_pkg::*;
#(
    parameter int FEAT_W = DTC_FEAT_W,
    parameter int CLS_W  = DTC_CLS_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FEAT_W-1:0] s_feat,
    output logic [FEAT_W-1:0] dt_inp,
    input  logic [CLS_W-1:0]  dt_outp,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FEAT_W-1:0] m_feat,
    output logic [CLS_W-1:0]  m_class,
    input  logic              cnt_clr,
    input  logic [CLS_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [LW-1:0]     fifo_level
);

    localparam int NCLS = 1 << CLS_W;
    localparam int RW   = FEAT_W + CLS_W;

    logic [FEAT_W-1:0] feat_q, feat_d;
    logic              stage_q, stage_d;
    logic [CNT_W-1:0]  cnt_q [NCLS];
    logic [CNT_W-1:0]  cnt_d [NCLS];
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic [RW-1:0]     head;

    assign s_ready = !stage_q || !fifo_full;
    assign accept  = s_valid && s_ready;
    assign push    = stage_q && !fifo_full;
    assign pop     = m_valid && m_ready;
    assign dt_inp  = feat_q;
    assign m_valid = !fifo_empty;
    assign m_feat  = head[RW-1:CLS_W];
    assign m_class = head[CLS_W-1:0];
    assign cnt_val = cnt_q[cnt_sel];

    dtc_result_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({feat_q, dt_outp}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Stage next state: a new sample wins over the drain into the FIFO.
    always_comb begin
        feat_d  = feat_q;
        stage_d = stage_q;
        if (push)   stage_d = 1'b0;
        if (accept) begin
            feat_d  = s_feat;
            stage_d = 1'b1;
        end
    end

    // Counter next state: clear drops any same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            for (int i = 0; i < NCLS; i++) cnt_d[i] = '0;
        end else if (push) begin
            cnt_d[dt_outp] = CNT_W'(sat_inc(32'(cnt_q[dt_outp]), CNT_W));
        end
    end

    // Stage and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q  <= '0;
            stage_q <= 1'b0;
            for (int i = 0; i < NCLS; i++) cnt_q[i] <= '0;
        end else begin
            feat_q  <= feat_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dtc_stream_driver.sv
// Self-checking bench for dtc_stream_driver.
// Queue-based reference model of stage + FIFO + class histogram.
module tb_dtc_stream_driver;
    import dtc_pkg::*;

    localparam int FW    = DTC_FEAT_W;
    localparam int CW    = DTC_CLS_W;
    localparam int DEPTH = 4;
    localparam int CNTW  = 4;
    localparam int NCLS  = 1 << CW;
    localparam int CMAX  = (1 << CNTW) - 1;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [FW-1:0]   s_feat = '0;
    logic [FW-1:0]   dt_inp;
    logic [CW-1:0]   dt_outp;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [FW-1:0]   m_feat;
    logic [CW-1:0]   m_class;
    logic            cnt_clr = 1'b0;
    logic [CW-1:0]   cnt_sel = '0;
    logic [CNTW-1:0] cnt_val;
    logic [LW-1:0]   fifo_level;

    int total = 0;
    int bad   = 0;
    int nacc  = 0;
    int cnt [NCLS];
    dtc_res_t stq[$];
    dtc_res_t fq[$];

    always #5 clk = ~clk;

    // Stand-in classifier: class is the low feature bits.
    assign dt_outp = dt_inp[CW-1:0];

    dtc_stream_driver #(
        .FEAT_W (FW),
        .CLS_W  (CW),
        .DEPTH  (DEPTH),
        .CNT_W  (CNTW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_feat     (s_feat),
        .dt_inp     (dt_inp),
        .dt_outp    (dt_outp),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_feat     (m_feat),
        .m_class    (m_class),
        .cnt_clr    (cnt_clr),
        .cnt_sel    (cnt_sel),
        .cnt_val    (cnt_val),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        stq.delete();
        fq.delete();
        for (int i = 0; i < NCLS; i++) cnt[i] = 0;
    endtask

    // One clock: check outputs vs model, then advance model at the edge.
    task automatic cycle();
        bit full, stg, pop, push, acc;
        dtc_res_t h;
        if (!rst_n) model_clear();
        #1;
        full = (fq.size() == DEPTH);
        stg  = (stq.size() != 0);
        chk("s_ready", s_ready, !(stg && full));
        chk("m_valid", m_valid, fq.size() != 0);
        chk("level", fifo_level, fq.size());
        chk("cnt_val", cnt_val, cnt[cnt_sel]);
        if (fq.size() != 0) begin
            chk("m_feat", m_feat, fq[0].feat);
            chk("m_class", m_class, fq[0].cls);
        end
        if (stg) chk("dt_inp", dt_inp, stq[0].feat);
        pop  = rst_n && m_ready && fq.size() != 0;
        push = rst_n && stg && !full;
        acc  = rst_n && s_valid && !(stg && full);
        @(posedge clk);
        if (pop) void'(fq.pop_front());
        if (push) begin
            h = stq.pop_front();
            fq.push_back(h);
            if (!cnt_clr) cnt[h.cls] = (cnt[h.cls] >= CMAX) ? CMAX : cnt[h.cls] + 1;
        end
        if (rst_n && cnt_clr)
            for (int i = 0; i < NCLS; i++) cnt[i] = 0;
        if (acc) begin
            h.feat = s_feat;
            h.cls  = s_feat[CW-1:0];
            stq.push_back(h);
            nacc++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] r;
        model_clear();
        @(negedge clk);

        // Reset held with s_valid high.
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_feat  = 8'h13;
        for (int s = 0; s < NCLS; s++) begin
            cnt_sel = CW'(s);
            #1 chk("rst_cnt", cnt_val, 0);
            cycle();
        end
        #1 chk("rst_dtinp", dt_inp, 0);
        chk("rst_ready", s_ready, 1);

        // First sample latency.
        rst_n   = 1'b1;
        m_ready = 1'b1;
        cycle();
        s_valid = 1'b0;
        cycle();
        #1 chk("lat_valid", m_valid, 1);
        chk("lat_feat", m_feat, 8'h13);
        chk("lat_class", m_class, 3);
        cycle();

        // Back-to-back streaming of 0x00..0x0F.
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_feat  = FW'(i);
            cycle();
        end
        s_valid = 1'b0;
        repeat (4) cycle();
        for (int s = 0; s < NCLS; s++) begin
            cnt_sel = CW'(s);
            #1 chk("stream_cnt", cnt_val, 4);
            cycle();
        end

        // Back-pressure fill until s_ready drops.
        m_ready = 1'b0;
        nacc    = 0;
        for (int k = 0; k < 20; k++) begin
            s_valid = 1'b1;
            s_feat  = FW'($urandom);
            #1;
            if (!s_ready) break;
            cycle();
        end
        chk("bp_accepted", nacc, DEPTH + 1);
        chk("bp_level", fifo_level, DEPTH);
        chk("bp_ready", s_ready, 0);

        // One pop while full, then the stage refills the FIFO.
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        cycle();
        #1 chk("full_pp_level", fifo_level, DEPTH);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (8) cycle();

        // Saturation at 2**CNT_W-1 for class 2.
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        cnt_sel = 2'd2;
        for (int i = 0; i < 20; i++) begin
            r       = 8'($urandom);
            s_valid = 1'b1;
            s_feat  = {r[7:2], 2'b10};
            cycle();
        end
        s_valid = 1'b0;
        repeat (3) cycle();
        #1 chk("sat_cnt", cnt_val, CMAX);

        // Clear coincident with a class-2 write.
        s_valid = 1'b1;
        s_feat  = 8'h42;
        cycle();
        s_valid = 1'b0;
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        cycle();
        #1 chk("clr_wins", cnt_val, 0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            s_valid = ($urandom % 4) != 0;
            m_ready = ($urandom % 3) != 0;
            s_feat  = FW'($urandom);
            cnt_sel = CW'($urandom);
            cnt_clr = ($urandom % 50) == 0;
            cycle();
        end
        cnt_clr = 1'b0;

        // Mid-stream reset with results queued.
        m_ready = 1'b0;
        s_valid = 1'b0;
        repeat (6) cycle();
        m_ready = 1'b1;
        repeat (6) cycle();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_feat  = FW'(8'h30 + i);
            cycle();
        end
        s_valid = 1'b0;
        cycle();
        #1 chk("pre_rst_level", fifo_level, 3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1 chk("post_rst_valid", m_valid, 0);
        chk("post_rst_level", fifo_level, 0);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_feat  = 8'h21;
        cycle();
        s_valid = 1'b0;
        cycle();
        #1 chk("post_rst_feat", m_feat, 8'h21);
        chk("post_rst_class", m_class, 1);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
